// File: rtl/gardner_pkg.sv
// Shared Q-format widths, constants and divider state encoding for the
// Gardner timing controller.
package gardner_pkg;

   localparam int unsigned W_WK = 16;
   localparam int unsigned W_MU = 15;

   localparam logic [W_WK-1:0] ONE = 16'h8000;

   // Index of the final quotient iteration (15 iterations, cnt 0..14).
   localparam logic [3:0] DIV_LAST = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_DONE
   } div_state_e;

endpackage

// File: rtl/gardner_mu_div.sv
// Restoring divider producing mu = floor(rem * 2^15 / div), MSB first,
// one quotient bit per clock; start restarts, abort drops to IDLE.
module gardner_mu_div
   import gardner_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            abort,
   input  logic [W_WK-1:0] rem_init,
   input  logic [W_WK-1:0] div_init,
   output logic            busy,
   output logic            done,
   output logic [W_MU-1:0] q
);

   div_state_e      state_q, state_d;
   logic [W_WK-1:0] rem_q, rem_d;
   logic [W_WK-1:0] div_q, div_d;
   logic [W_MU-1:0] q_q, q_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [W_WK-1:0] shl;
   logic            ge;

   always_comb begin
      // rem < div always holds, so the 16-bit subtraction cannot lose a bit;
      // rem's MSB stands in for bit 16 of the doubled remainder.
      shl     = {rem_q[W_WK-2:0], 1'b0};
      ge      = rem_q[W_WK-1] | (shl >= div_q);
      state_d = state_q;
      rem_d   = rem_q;
      div_d   = div_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d = ST_DIV;
         rem_d   = rem_init;
         div_d   = div_init;
         q_d     = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_DIV: begin
               q_d   = {q_q[W_MU-2:0], ge};
               rem_d = ge ? (shl - div_q) : shl;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == DIV_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         div_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign q    = q_q;

endmodule

// File: rtl/gardner_nco_ctrl.sv
// Modulo-1 NCO timing controller for Gardner symbol sync: steps by the
// clamped wk per sample and issues strobe + mu = eta/wk on each underflow.
module gardner_nco_ctrl
   import gardner_pkg::*;
#(
   parameter logic [W_WK-1:0] ETA_INIT = 16'h7FFF,
   parameter logic [W_WK-1:0] WK_MIN   = 16'h1000,
   parameter logic [W_WK-1:0] WK_MAX   = 16'h7000
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            enable,
   input  logic            sample_valid,
   input  logic [W_WK-1:0] wk,
   input  logic            clr_err,
   output logic            strobe,
   output logic [W_MU-1:0] mu,
   output logic            busy,
   output logic            overrun_err,
   output logic [W_WK-1:0] eta_dbg
);

   logic [W_WK-1:0] eta_q, eta_d;
   logic [W_MU-1:0] mu_q, mu_d;
   logic            strobe_q, strobe_d;
   logic            ovr_q, ovr_d;
   logic [W_WK-1:0] wk_c;
   logic [W_WK:0]   diff;
   logic            sample_en;
   logic            start;
   logic            div_busy;
   logic            div_done;
   logic [W_MU-1:0] div_q;

   always_comb begin
      wk_c = wk;
      if ($signed(wk) < $signed(WK_MIN))      wk_c = WK_MIN;
      else if ($signed(wk) > $signed(WK_MAX)) wk_c = WK_MAX;
      diff      = {1'b0, eta_q} - {1'b0, wk_c};
      sample_en = enable & sample_valid;
      start     = sample_en & diff[W_WK];
      eta_d = eta_q;
      if (sample_en) eta_d = diff[W_WK] ? (diff[W_WK-1:0] + ONE) : diff[W_WK-1:0];
      ovr_d = ovr_q;
      if (start && div_busy) ovr_d = 1'b1;
      else if (clr_err)      ovr_d = 1'b0;
      // A restart on the DONE cycle discards the finished quotient.
      strobe_d = enable & div_done & ~start;
      mu_d     = strobe_d ? div_q : mu_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eta_q    <= ETA_INIT;
         mu_q     <= '0;
         strobe_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         eta_q    <= eta_d;
         mu_q     <= mu_d;
         strobe_q <= strobe_d;
         ovr_q    <= ovr_d;
      end
   end

   gardner_mu_div u_div (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .abort    (~enable),
      .rem_init (eta_q),
      .div_init (wk_c),
      .busy     (div_busy),
      .done     (div_done),
      .q        (div_q)
   );

   assign strobe      = strobe_q;
   assign mu          = mu_q;
   assign busy        = div_busy;
   assign overrun_err = ovr_q;
   assign eta_dbg     = eta_q;

endmodule

// File: tb/tb_gardner_nco_ctrl.sv
// Scoreboard bench for gardner_nco_ctrl: an arithmetic NCO model queues the
// expected mu and strobe cycle; a monitor pops and compares on each strobe.
module tb_gardner_nco_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] wk = '0;
   logic        clr_err = 1'b0;
   logic        strobe;
   logic [14:0] mu;
   logic        busy;
   logic        overrun_err;
   logic [15:0] eta_dbg;

   gardner_nco_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (enable),
      .sample_valid (sample_valid),
      .wk           (wk),
      .clr_err      (clr_err),
      .strobe       (strobe),
      .mu           (mu),
      .busy         (busy),
      .overrun_err  (overrun_err),
      .eta_dbg      (eta_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [14:0] mu;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_pass = 0;
   int          n_total = 0;

   int          eta_m;
   bit          ovr_m;
   bit          en_m;
   bit          pend_valid;
   int          pend_cyc;
   logic [14:0] pend_mu;
   logic [14:0] hold_mu;

   task automatic check(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   always @(negedge clk) begin
      if (resetn && strobe) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_mu", int'(mu), int'(e.mu));
            check("strobe_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic upd_hold(input int now);
      if (pend_valid && now >= pend_cyc) begin
         hold_mu    = pend_mu;
         pend_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      exp_q.delete();
      eta_m = 32'h7FFF; ovr_m = 1'b0; pend_valid = 1'b0; hold_mu = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      enable = 1'b1; en_m = 1'b1;
      @(negedge clk);
   endtask

   // Issue one sample at the current negedge; returns 'gap' negedges later.
   task automatic sample(input logic [15:0] w, input bit clr, input int gap);
      int wkc;
      int now;
      bit set;
      exp_t e;
      now = cyc;
      set = 1'b0;
      wkc = int'($signed(w));
      if (wkc < 4096) wkc = 4096;
      else if (wkc > 28672) wkc = 28672;
      upd_hold(now);
      wk = w; sample_valid = 1'b1; clr_err = clr;
      if (en_m) begin
         if (eta_m >= wkc) begin
            eta_m = eta_m - wkc;
         end else begin
            if (pend_valid && now < pend_cyc) begin
               void'(exp_q.pop_back());
               set = 1'b1;
            end
            e.mu  = 15'((eta_m * 32768) / wkc);
            e.cyc = now + 17;
            exp_q.push_back(e);
            pend_valid = 1'b1; pend_cyc = e.cyc; pend_mu = e.mu;
            eta_m = eta_m - wkc + 32768;
         end
      end
      if (set) ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
      @(negedge clk);
      sample_valid = 1'b0; clr_err = 1'b0;
      upd_hold(cyc);
      check("eta", int'(eta_dbg), eta_m);
      check("overrun", int'(overrun_err), int'(ovr_m));
      check("busy", int'(busy), int'(pend_valid && cyc < pend_cyc));
      check("mu_hold", int'(mu), int'(hold_mu));
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic drop_enable();
      upd_hold(cyc);
      if (pend_valid && cyc < pend_cyc) begin
         void'(exp_q.pop_back());
         pend_valid = 1'b0;
      end
      enable = 1'b0; en_m = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_eta", int'(eta_dbg), 32'h7FFF);
      check("rst_strobe", int'(strobe), 0);
      check("rst_mu", int'(mu), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovr", int'(overrun_err), 0);

      // wk = 0.5: underflow every second sample, mu 7FFE
      for (int i = 0; i < 6; i++) sample(16'h4000, 1'b0, 20);

      do_reset();
      sample(16'h6000, 1'b0, 20);
      sample(16'h6000, 1'b0, 20);

      do_reset();
      sample(16'h0000, 1'b0, 20);
      sample(16'hC000, 1'b0, 20);
      do_reset();
      sample(16'h7FFF, 1'b0, 20);

      // back-to-back underflows force overruns; clr_err loses to a new set
      do_reset();
      sample(16'h7000, 1'b0, 17);
      sample(16'h7000, 1'b0, 8);
      sample(16'h7000, 1'b0, 8);
      sample(16'h7000, 1'b1, 20);
      sample(16'h1000, 1'b1, 20);
      sample(16'h1000, 1'b0, 20);

      // enable dropped at cnt=5 of a division
      do_reset();
      sample(16'h4000, 1'b0, 20);
      sample(16'h4000, 1'b0, 1);
      repeat (5) @(negedge clk);
      drop_enable();
      @(negedge clk);
      check("dis_busy", int'(busy), 0);
      check("dis_eta", int'(eta_dbg), eta_m);
      sample(16'h4000, 1'b0, 20);
      enable = 1'b1; en_m = 1'b1;
      sample(16'h4000, 1'b0, 20);
      sample(16'h4000, 1'b0, 20);

      // asynchronous reset mid-division with overrun set
      do_reset();
      sample(16'h7000, 1'b0, 17);
      sample(16'h7000, 1'b0, 8);
      sample(16'h7000, 1'b0, 4);
      #2 resetn = 1'b0;
      #1;
      check("arst_strobe", int'(strobe), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_ovr", int'(overrun_err), 0);
      check("arst_eta", int'(eta_dbg), 32'h7FFF);
      do_reset();

      for (int i = 0; i < 60; i++) begin
         logic [15:0] w;
         case ($urandom_range(0, 3))
            0:       w = 16'($urandom_range(0, 65535));
            1:       w = 16'($urandom_range(16'h0F00, 16'h7100));
            default: w = 16'($urandom_range(16'h2000, 16'h6000));
         endcase
         sample(w, $urandom_range(0, 7) == 0, $urandom_range(17, 24));
      end

      repeat (30) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
